// File: rtl/clmul_pkg.sv
// Shared types and helpers for the digit-serial carry-less multiplier:
// FSM state encoding, digit-count arithmetic and a bitwise reference product.
package clmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } clmul_state_e;

  // Widest operand the reference product handles; narrower operands are zero-extended.
  localparam int CLMUL_REF_W = 32;

  function automatic int clmul_ndig(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction

  function automatic logic [2*CLMUL_REF_W-1:0] clmul_ref(input logic [CLMUL_REF_W-1:0] a,
                                                         input logic [CLMUL_REF_W-1:0] b);
    logic [2*CLMUL_REF_W-1:0] p;
    p = '0;
    for (int i = 0; i < CLMUL_REF_W; i++) begin
      if (b[i]) begin
        p = p ^ ({{CLMUL_REF_W{1'b0}}, a} << i);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/clmul_digit_serial_if.sv
// Operand/result handshake bundle between a producer and the digit-serial multiplier.
interface clmul_digit_serial_if #(
  parameter int WIDTH = 11
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               acc_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-2:0] y;

  modport master (
    output in_valid, a, b, acc_mode, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, acc_mode, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/clmul_pp_wxd.sv
// Combinational WIDTH x DIGIT carry-less partial product (WIDTH+DIGIT-1 bits).
module clmul_pp_wxd #(
  parameter int WIDTH = 11,
  parameter int DIGIT = 4
) (
  input  logic [WIDTH-1:0]       i_a,
  input  logic [DIGIT-1:0]       i_d,
  output logic [WIDTH+DIGIT-2:0] o_p
);
  localparam int PW = WIDTH + DIGIT - 1;

  logic [PW-1:0] w_p;

  // XOR together the shifted copies of a selected by each digit bit
  always_comb begin
    w_p = '0;
    for (int j = 0; j < DIGIT; j++) begin
      w_p = w_p ^ ((PW'(i_a) << j) & {PW{i_d[j]}});
    end
  end

  assign o_p = w_p;
endmodule

// File: rtl/clmul_digit_serial.sv
// Digit-serial GF(2)[x] multiplier: consumes DIGIT bits of b per cycle and
// delivers the full 2*WIDTH-1 bit product, optionally XORed into the previous y.
module clmul_digit_serial
  import clmul_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DIGIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  clmul_digit_serial_if.slave bus
);
  localparam int NDIG = clmul_ndig(WIDTH, DIGIT);
  localparam int BW   = NDIG * DIGIT;
  localparam int YW   = 2 * WIDTH - 1;
  localparam int PW   = WIDTH + DIGIT - 1;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  clmul_state_e     r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [BW-1:0]    r_b;
  logic [YW-1:0]    r_acc;
  logic [YW-1:0]    r_y;
  logic [CW-1:0]    r_cnt;

  logic [PW-1:0]    w_pp;
  logic [YW-1:0]    w_term;
  logic [YW-1:0]    w_acc_next;

  // r_b shifts right every digit, so the current digit is always its LSBs
  clmul_pp_wxd #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_pp (
    .i_a (r_a),
    .i_d (r_b[DIGIT-1:0]),
    .o_p (w_pp)
  );

  // pp fits in YW bits, so bits shifted past the top are structurally zero
  assign w_term     = YW'(w_pp) << (int'(r_cnt) * DIGIT);
  assign w_acc_next = r_acc ^ w_term;

  // Control FSM with counter, accumulator and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= BW'(bus.b);
            r_acc      <= bus.acc_mode ? r_y : '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_BUSY: begin
          r_acc <= w_acc_next;
          r_b   <= r_b >> DIGIT;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_y         <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
endmodule

// File: tb/tb_clmul_digit_serial.sv
// Self-checking bench: directed scenarios on DIGIT=4 plus scoreboard-checked
// random sweeps on DIGIT=1, 4 and 11 instances sharing one stimulus bus.
module tb_clmul_digit_serial;
  import clmul_pkg::*;

  localparam int W  = 11;
  localparam int YW = 2 * W - 1;

  logic clk;
  logic rst_n;

  int          sel;
  logic        drv_valid;
  logic        drv_acc;
  logic        drv_ready;
  logic [W-1:0] drv_a;
  logic [W-1:0] drv_b;

  logic          mon_in_ready;
  logic          mon_out_valid;
  logic [YW-1:0] mon_y;

  int checks;
  int failures;

  logic [YW-1:0] sb[$];
  logic [YW-1:0] prev_y[3];

  clmul_digit_serial_if #(.WIDTH(W)) if_d1  ();
  clmul_digit_serial_if #(.WIDTH(W)) if_d4  ();
  clmul_digit_serial_if #(.WIDTH(W)) if_d11 ();

  assign if_d1.in_valid   = drv_valid && (sel == 0);
  assign if_d4.in_valid   = drv_valid && (sel == 1);
  assign if_d11.in_valid  = drv_valid && (sel == 2);
  assign if_d1.a = drv_a;   assign if_d1.b = drv_b;
  assign if_d4.a = drv_a;   assign if_d4.b = drv_b;
  assign if_d11.a = drv_a;  assign if_d11.b = drv_b;
  assign if_d1.acc_mode  = drv_acc;
  assign if_d4.acc_mode  = drv_acc;
  assign if_d11.acc_mode = drv_acc;
  assign if_d1.out_ready  = drv_ready;
  assign if_d4.out_ready  = drv_ready;
  assign if_d11.out_ready = drv_ready;

  clmul_digit_serial #(.WIDTH(W), .DIGIT(1))  u_dut_d1  (.clk(clk), .rst_n(rst_n), .bus(if_d1));
  clmul_digit_serial #(.WIDTH(W), .DIGIT(4))  u_dut     (.clk(clk), .rst_n(rst_n), .bus(if_d4));
  clmul_digit_serial #(.WIDTH(W), .DIGIT(11)) u_dut_d11 (.clk(clk), .rst_n(rst_n), .bus(if_d11));

  always_comb begin
    case (sel)
      0:       begin mon_in_ready = if_d1.in_ready;  mon_out_valid = if_d1.out_valid;  mon_y = if_d1.y;  end
      2:       begin mon_in_ready = if_d11.in_ready; mon_out_valid = if_d11.out_valid; mon_y = if_d11.y; end
      default: begin mon_in_ready = if_d4.in_ready;  mon_out_valid = if_d4.out_valid;  mon_y = if_d4.y;  end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [YW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic acc, input logic [YW-1:0] prev);
    logic [63:0] r;
    r = clmul_ref({21'd0, a}, {21'd0, b});
    return r[YW-1:0] ^ (acc ? prev : {YW{1'b0}});
  endfunction

  // Called at a negedge; offers one operand pair and returns at the negedge after acceptance
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic acc,
                       input logic [YW-1:0] exp_y, input bit push);
    int n;
    n = 0;
    while (!mon_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mon_in_ready) begin
      failures++;
      $display("FAIL issue_timeout in_ready=%0b required=1", mon_in_ready);
    end else begin
      drv_a = a; drv_b = b; drv_acc = acc; drv_valid = 1'b1;
      if (push) begin
        sb.push_back(exp_y);
        prev_y[sel] = exp_y;
      end
      @(negedge clk);
      drv_valid = 1'b0;
    end
  endtask

  task automatic collect(output logic [YW-1:0] got, output int lat, output bit ok);
    lat = 0;
    while (!mon_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    ok  = mon_out_valid;
    got = mon_y;
    if (ok) begin
      drv_ready = 1'b1;
      @(negedge clk);
      drv_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    sel = 1; drv_valid = 1'b0; drv_ready = 1'b0; drv_acc = 1'b0; drv_a = '0; drv_b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mon_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", mon_in_ready); end
    checks++; if (mon_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", mon_out_valid); end
    checks++; if (mon_y !== 21'h000000) begin failures++; $display("FAIL reset_y got=%h exp=000000", mon_y); end
    rst_n = 1'b1;
    prev_y[0] = '0; prev_y[1] = '0; prev_y[2] = '0;
    @(negedge clk);
    checks++; if (mon_in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", mon_in_ready); end
  endtask

  task automatic test_basic();
    logic [YW-1:0] got, exp;
    int lat; bit ok;
    issue(11'h7FF, 11'h7FF, 1'b0, 21'h155555, 1'b1);
    collect(got, lat, ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 21'h0;
    checks++; if (lat != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    checks++; if (!ok || got !== exp) begin failures++; $display("FAIL basic_y got=%h exp=%h", got, exp); end
  endtask

  task automatic test_top_bit();
    logic [YW-1:0] got, exp;
    int lat; bit ok;
    issue(11'h001, 11'h400, 1'b0, 21'h000400, 1'b1);
    collect(got, lat, ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 21'h0;
    checks++; if (!ok || got !== exp) begin failures++; $display("FAIL partial_digit_y got=%h exp=%h", got, exp); end
    issue(11'h400, 11'h400, 1'b0, 21'h100000, 1'b1);
    collect(got, lat, ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 21'h0;
    checks++; if (!ok || got !== exp) begin failures++; $display("FAIL top_bit_y got=%h exp=%h", got, exp); end
  endtask

  task automatic test_acc();
    logic [YW-1:0] got, exp;
    int lat; bit ok;
    issue(11'h003, 11'h003, 1'b0, 21'h000005, 1'b1);
    collect(got, lat, ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 21'h0;
    checks++; if (!ok || got !== exp) begin failures++; $display("FAIL acc_first_y got=%h exp=%h", got, exp); end
    issue(11'h002, 11'h001, 1'b1, 21'h000007, 1'b1);
    collect(got, lat, ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 21'h0;
    checks++; if (!ok || got !== exp) begin failures++; $display("FAIL acc_second_y got=%h exp=%h", got, exp); end
  endtask

  task automatic test_backpressure();
    logic [YW-1:0] exp;
    int n; bit extra;
    issue(11'h00F, 11'h011, 1'b0, 21'h0000FF, 1'b1);
    n = 0;
    while (!mon_out_valid && n < 200) begin @(negedge clk); n++; end
    checks++; if (!mon_out_valid) begin failures++; $display("FAIL bp_done_timeout out_valid=%0b exp=1", mon_out_valid); end
    exp = (sb.size() != 0) ? sb.pop_front() : 21'h0;
    for (int i = 0; i < 5; i++) begin
      drv_valid = 1'b1; drv_a = 11'h3A5; drv_b = 11'h1C3; drv_acc = 1'b1; drv_ready = 1'b0;
      @(negedge clk);
      checks++; if (mon_y !== exp) begin failures++; $display("FAIL bp_y_stable cycle=%0d got=%h exp=%h", i, mon_y, exp); end
      checks++; if (mon_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%0b exp=0", i, mon_in_ready); end
      checks++; if (mon_out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cycle=%0d got=%0b exp=1", i, mon_out_valid); end
    end
    drv_valid = 1'b0; drv_ready = 1'b1;
    @(negedge clk);
    drv_ready = 1'b0;
    checks++; if (mon_out_valid !== 1'b0 || mon_in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release out_valid=%0b in_ready=%0b exp=0/1", mon_out_valid, mon_in_ready);
    end
    extra = 1'b0;
    repeat (6) begin @(negedge clk); if (mon_out_valid) extra = 1'b1; end
    checks++; if (extra) begin failures++; $display("FAIL bp_ignored_in_valid extra_result=1 exp=0"); end
    checks++; if (mon_y !== exp) begin failures++; $display("FAIL bp_y_retained got=%h exp=%h", mon_y, exp); end
  endtask

  task automatic test_reset_mid();
    logic [YW-1:0] got, exp;
    int lat; bit ok, spurious;
    issue(11'h0AA, 11'h055, 1'b0, 21'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (mon_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%0b exp=0", mon_out_valid); end
    checks++; if (mon_y !== 21'h0) begin failures++; $display("FAIL midrst_y got=%h exp=000000", mon_y); end
    checks++; if (mon_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%0b exp=1", mon_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    prev_y[0] = '0; prev_y[1] = '0; prev_y[2] = '0;
    spurious = 1'b0;
    repeat (4) begin @(negedge clk); if (mon_out_valid) spurious = 1'b1; end
    checks++; if (spurious) begin failures++; $display("FAIL midrst_no_output spurious=1 exp=0"); end
    issue(11'h005, 11'h003, 1'b1, 21'h00000F, 1'b1);
    collect(got, lat, ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 21'h0;
    checks++; if (!ok || got !== exp) begin failures++; $display("FAIL midrst_acc_y got=%h exp=%h", got, exp); end
  endtask

  task automatic test_latency();
    logic [YW-1:0] got, exp;
    int lat; bit ok;
    int exp_lat[3];
    exp_lat[0] = 11; exp_lat[1] = 3; exp_lat[2] = 1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      @(negedge clk);
      issue(11'h7FF, 11'h7FF, 1'b0, 21'h155555, 1'b1);
      collect(got, lat, ok);
      exp = (sb.size() != 0) ? sb.pop_front() : 21'h0;
      checks++; if (lat != exp_lat[s]) begin failures++; $display("FAIL latency_sel%0d got=%0d exp=%0d", s, lat, exp_lat[s]); end
      checks++; if (!ok || got !== exp) begin failures++; $display("FAIL latency_y_sel%0d got=%h exp=%h", s, got, exp); end
    end
    sel = 1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int results;
    sel = 1;
    drv_a = 11'h001; drv_b = 11'h001; drv_acc = 1'b0; drv_valid = 1'b1; drv_ready = 1'b1;
    results = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (mon_in_ready && mon_out_valid) begin failures++; $display("FAIL b2b_overlap cycle=%0d in_ready=1 out_valid=1 exp=not both", i); end
      if (mon_out_valid) begin
        results++;
        checks++; if (mon_y !== 21'h000001) begin failures++; $display("FAIL b2b_y got=%h exp=000001", mon_y); end
      end
    end
    drv_valid = 1'b0; drv_ready = 1'b0;
    prev_y[1] = 21'h000001;
    checks++; if (results != 8) begin failures++; $display("FAIL b2b_throughput got=%0d exp=8", results); end
    @(negedge clk);
  endtask

  task automatic test_random_sweep(input int s, input int n);
    int pushed, done, cyc;
    logic [YW-1:0] exp;
    logic [W-1:0] ra, rb;
    logic racc;
    sel = s;
    pushed = 0; done = 0; cyc = 0;
    @(negedge clk);
    while (done < n && cyc < n * 40) begin
      drv_ready = ($urandom_range(0, 3) != 0);
      checks++; if (mon_in_ready && mon_out_valid) begin failures++; $display("FAIL sweep%0d_overlap in_ready=1 out_valid=1 exp=not both", s); end
      if (mon_out_valid && drv_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL sweep%0d_unexpected_result got=%h exp=none", s, mon_y);
        end else begin
          exp = sb.pop_front();
          if (mon_y !== exp) begin failures++; $display("FAIL sweep%0d_y got=%h exp=%h", s, mon_y, exp); end
        end
        done++;
      end
      if (mon_in_ready && pushed < n) begin
        ra = W'($urandom_range(0, 2047));
        rb = W'($urandom_range(0, 2047));
        racc = 1'($urandom_range(0, 1));
        drv_a = ra; drv_b = rb; drv_acc = racc; drv_valid = 1'b1;
        exp = model(ra, rb, racc, prev_y[s]);
        sb.push_back(exp);
        prev_y[s] = exp;
        pushed++;
      end else begin
        drv_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    drv_valid = 1'b0; drv_ready = 1'b0;
    checks++; if (done != n) begin failures++; $display("FAIL sweep%0d_timeout got=%0d exp=%0d", s, done, n); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sweep%0d_leftover got=%0d exp=0", s, sb.size()); end
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_top_bit();
    test_acc();
    test_backpressure();
    test_reset_mid();
    test_latency();
    test_back_to_back();
    test_random_sweep(0, 2000);
    test_random_sweep(1, 4000);
    test_random_sweep(2, 4000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
